// File: rtl/smart_home_scheduler_if.sv
// Sensor and actuator bundle for the smart-home scheduler.
// master: the environment that drives the raw sensors and temperature and
//         observes the actuator enables and grant code.
// slave : the scheduler itself.
// Signals:
//   SFD, SRD, SW, SFA : raw front door, rear door, window and fire sensors
//   ST                : unsigned 7-bit temperature
//   fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler : actuator enables
//   display           : current grant code
interface smart_home_scheduler_if;
    logic       SFD;
    logic       SRD;
    logic       SW;
    logic       SFA;
    logic [6:0] ST;
    logic       fdoor;
    logic       rdoor;
    logic       winbuzz;
    logic       alarmbuzz;
    logic       heater;
    logic       cooler;
    logic [2:0] display;

    modport master (
        output SFD, SRD, SW, SFA, ST,
        input  fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, display
    );

    modport slave (
        input  SFD, SRD, SW, SFA, ST,
        output fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, display
    );
endinterface

// File: rtl/smart_home_scheduler.sv
// Smart-home actuator scheduler.
// Debounces the door/window/fire sensors, applies hysteresis to the
// temperature, and grants one actuator at a time by fixed priority with a
// minimum dwell. Fire preempts any grant at once.
// Ports:
//   clk  : rising-edge clock
//   Rst  : synchronous active-high reset
//   bus  : sensor inputs, actuator enables and display (slave side)
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | nothing granted, display 000
// FD    | front door actuator, display 001
// RD    | rear door actuator, display 010
// ALARM | fire alarm buzzer, display 011
// WIN   | window buzzer, display 100
// HEAT  | heater, display 101
// COOL  | cooler, display 110
module smart_home_scheduler #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int HEAT_ON     = 50,
    parameter int HEAT_OFF    = 60,
    parameter int COOL_ON     = 85,
    parameter int COOL_OFF    = 75
) (
    input logic                 clk,
    input logic                 Rst,
    smart_home_scheduler_if.slave bus
);
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_V      = DCW'(DEB_CYCLES);
    localparam logic [HCW-1:0] HOLD_M1    = HCW'(HOLD_CYCLES - 1);
    localparam logic [6:0]     HEAT_ON_V  = 7'(HEAT_ON);
    localparam logic [6:0]     HEAT_OFF_V = 7'(HEAT_OFF);
    localparam logic [6:0]     COOL_ON_V  = 7'(COOL_ON);
    localparam logic [6:0]     COOL_OFF_V = 7'(COOL_OFF);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_FD    = 3'b001,
        S_RD    = 3'b010,
        S_ALARM = 3'b011,
        S_WIN   = 3'b100,
        S_HEAT  = 3'b101,
        S_COOL  = 3'b110
    } state_t;

    // bit order: 0 front door, 1 rear door, 2 window, 3 fire
    logic [3:0]     raw;
    logic [3:0]     filt;
    logic [DCW-1:0] deb_cnt [4];
    logic [6:0]     st_q;
    logic           heat_req;
    logic           cool_req;
    state_t         state;
    state_t         best;
    logic [HCW-1:0] dwell;

    assign raw = {bus.SFA, bus.SW, bus.SRD, bus.SFD};

    // A sensor flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (Rst) begin
            filt <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (raw[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] + 1'b1 == DEB_V) begin
                    filt[i]    <= raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Hysteresis: the threshold ordering keeps the two flags exclusive.
    always_ff @(posedge clk) begin
        if (Rst) begin
            st_q     <= '0;
            heat_req <= 1'b0;
            cool_req <= 1'b0;
        end else begin
            st_q <= bus.ST;
            if (st_q < HEAT_ON_V)        heat_req <= 1'b1;
            else if (st_q >= HEAT_OFF_V) heat_req <= 1'b0;
            if (st_q > COOL_ON_V)        cool_req <= 1'b1;
            else if (st_q <= COOL_OFF_V) cool_req <= 1'b0;
        end
    end

    always_comb begin
        best = S_IDLE;
        if (filt[3])       best = S_ALARM;
        else if (filt[0])  best = S_FD;
        else if (filt[1])  best = S_RD;
        else if (filt[2])  best = S_WIN;
        else if (heat_req) best = S_HEAT;
        else if (cool_req) best = S_COOL;
    end

    // dwell is the number of further edges the current grant must be held;
    // it rests at 0 once expired so a better request is taken immediately.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state <= S_IDLE;
            dwell <= '0;
        end else if (3'(state) == 3'b111) begin
            state <= S_IDLE;
            dwell <= '0;
        end else if (filt[3] && state != S_ALARM) begin
            state <= S_ALARM;
            dwell <= HOLD_M1;
        end else if (dwell != '0) begin
            dwell <= dwell - 1'b1;
        end else if (best != state) begin
            state <= best;
            dwell <= (best == S_IDLE) ? '0 : HOLD_M1;
        end
    end

    assign bus.display   = state;
    assign bus.fdoor     = (state == S_FD);
    assign bus.rdoor     = (state == S_RD);
    assign bus.alarmbuzz = (state == S_ALARM);
    assign bus.winbuzz   = (state == S_WIN);
    assign bus.heater    = (state == S_HEAT);
    assign bus.cooler    = (state == S_COOL);
endmodule

// File: tb/tb_smart_home_scheduler.sv
// Randomized scoreboard bench for smart_home_scheduler.
module tb_smart_home_scheduler;
    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic clk;
    logic Rst;
    smart_home_scheduler_if bus ();

    smart_home_scheduler #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .HEAT_ON(50), .HEAT_OFF(60), .COOL_ON(85), .COOL_OFF(75)
    ) dut (
        .clk(clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // grant index: 0 idle, 1 front door, 2 rear door, 3 alarm, 4 window,
    // 5 heat, 6 cool. Output vector {fdoor,rdoor,winbuzz,alarmbuzz,heater,cooler}
    logic [2:0] disp_tab [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [5:0] out_tab  [7] = '{6'b000000, 6'b100000, 6'b010000, 6'b000100,
                                 6'b001000, 6'b000010, 6'b000001};

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];

    // Reference model state
    bit        m_f [4];
    bit [15:0] m_hist [4];
    int        m_n [4];
    int        m_stq;
    bit        m_heat;
    bit        m_cool;
    int        m_g;
    int        m_age;   // edges spent in the current grant since entering it

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_f[i] = 0; m_hist[i] = '0; m_n[i] = 0;
        end
        m_stq = 0; m_heat = 0; m_cool = 0; m_g = 0; m_age = 0;
    endfunction

    function automatic void model_step(bit rst, bit [3:0] raw, int st);
        int  best;
        bit  expired;
        bit  all_diff;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_f[3])      best = 3;
        else if (m_f[0]) best = 1;
        else if (m_f[1]) best = 2;
        else if (m_f[2]) best = 4;
        else if (m_heat) best = 5;
        else if (m_cool) best = 6;
        else             best = 0;
        expired = (m_g == 0) || (m_age >= HOLD - 1);
        if (m_f[3] && m_g != 3) begin
            m_g = 3; m_age = 0;
        end else if (expired && best != m_g) begin
            m_g = best; m_age = 0;
        end else if (m_age < 1000) begin
            m_age++;
        end
        if (m_stq < 50)       m_heat = 1;
        else if (m_stq >= 60) m_heat = 0;
        if (m_stq > 85)       m_cool = 1;
        else if (m_stq <= 75) m_cool = 0;
        m_stq = st;
        // A sensor flips when its last DEB samples since reset all disagree.
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][14:0], raw[i]};
            if (m_n[i] < 100) m_n[i]++;
            all_diff = 1;
            for (int k = 0; k < DEB; k++)
                if (m_hist[i][k] == m_f[i]) all_diff = 0;
            if (m_n[i] >= DEB && all_diff) m_f[i] = raw[i];
        end
    endfunction

    task automatic drive(bit rst, bit [3:0] raw, int st);
        @(negedge clk);
        Rst     = rst;
        bus.SFD = raw[0];
        bus.SRD = raw[1];
        bus.SW  = raw[2];
        bus.SFA = raw[3];
        bus.ST  = 7'(st);
        model_step(rst, raw, st);
        exp_q.push_back({disp_tab[m_g], out_tab[m_g]});
    endtask

    // Monitor: one expectation per rising edge, compared just after the edge.
    initial begin
        logic [8:0] e;
        logic [5:0] outs;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                outs = {bus.fdoor, bus.rdoor, bus.winbuzz, bus.alarmbuzz,
                        bus.heater, bus.cooler};
                checks++;
                if (bus.display !== e[8:6]) begin
                    errors++;
                    $display("FAIL display: got %b expected %b at %0t",
                             bus.display, e[8:6], $time);
                end
                checks++;
                if (outs !== e[5:0]) begin
                    errors++;
                    $display("FAIL actuators: got %b expected %b at %0t",
                             outs, e[5:0], $time);
                end
            end
        end
    end

    int st_vals [16] = '{30, 45, 49, 50, 55, 59, 60, 61, 70, 74, 75, 76, 80, 85, 86, 120};

    initial begin
        bit [3:0] raw;
        int       hold [4];
        int       st;
        int       st_hold;
        Rst = 1'b1;
        bus.SFD = 0; bus.SRD = 0; bus.SW = 0; bus.SFA = 0; bus.ST = '0;
        model_reset();

        // Reset with every sensor asserted and hot temperature, then release.
        repeat (2) drive(1'b1, 4'b1111, 90);
        repeat (12) drive(1'b0, 4'b1111, 90);
        // Short front-door glitch, then a held front door.
        repeat (20) drive(1'b0, 4'b0000, 70);
        repeat (3) drive(1'b0, 4'b0001, 70);
        repeat (6) drive(1'b0, 4'b0000, 70);
        repeat (4) drive(1'b0, 4'b0001, 70);
        repeat (14) drive(1'b0, 4'b0000, 70);
        // Heating then cooling hysteresis walk.
        repeat (14) drive(1'b0, 4'b0000, 40);
        repeat (14) drive(1'b0, 4'b0000, 55);
        repeat (14) drive(1'b0, 4'b0000, 60);
        repeat (14) drive(1'b0, 4'b0000, 90);
        repeat (14) drive(1'b0, 4'b0000, 80);
        repeat (14) drive(1'b0, 4'b0000, 75);

        raw = '0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        st = 70; st_hold = 0;
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    if (i == 3) begin
                        if (raw[3]) begin
                            raw[3] = 0; hold[3] = $urandom_range(40, 250);
                        end else if ($urandom_range(0, 3) == 0) begin
                            raw[3] = 1; hold[3] = $urandom_range(1, 14);
                        end else begin
                            hold[3] = $urandom_range(20, 120);
                        end
                    end else begin
                        raw[i] = ($urandom_range(0, 2) == 0);
                        hold[i] = $urandom_range(1, 16);
                    end
                end else begin
                    hold[i]--;
                end
            end
            if (st_hold == 0) begin
                st = st_vals[$urandom_range(0, 15)];
                st_hold = $urandom_range(2, 40);
            end else begin
                st_hold--;
            end
            drive(($urandom_range(0, 700) == 0), raw, st);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/smart_home_scheduler.md
# smart_home_scheduler

Arbitration and sequencing controller for the smart-home actuator outputs. Debounces the door, window and fire sensors and applies hysteresis to the temperature input. Grants exactly one actuator at a time by fixed priority and holds each grant for a minimum dwell time. Fire preempts any grant immediately. Drives the same actuator and display outputs as the existing home FSM and replaces its one-cycle decision logic with a scheduled, glitch-free sequence.

## Interface
- DEB_CYCLES, 4: consecutive stable samples required before a filtered sensor changes; ≥1.
- HOLD_CYCLES, 8: minimum cycles a granted state is held; ≥1.
- HEAT_ON, 50: heat request sets when registered ST < HEAT_ON.
- HEAT_OFF, 60: heat request clears when registered ST ≥ HEAT_OFF; HEAT_ON ≤ HEAT_OFF.
- COOL_ON, 85: cool request sets when registered ST > COOL_ON.
- COOL_OFF, 75: cool request clears when registered ST ≤ COOL_OFF; HEAT_OFF ≤ COOL_OFF ≤ COOL_ON.
- clk, in, 1: single clock; everything is on its rising edge.
- Rst, in, 1: synchronous, active-high reset.
- SFD / SRD / SW / SFA, in, 1 each: front door, rear door, window and fire-alarm sensors (raw, may glitch).
- ST, in, 7: unsigned temperature.
- fdoor / rdoor / winbuzz / alarmbuzz / heater / cooler, out, 1 each: actuator enables, one-hot or all zero.
- display, out, 3: current grant code.

## Operation
- Debounce, one instance per sensor:
  - Each sensor has a filtered bit `f_x` and a counter.
  - On each edge where raw ≠ f_x, the counter increments. When the counter would reach DEB_CYCLES, f_x takes the raw value and the counter clears.
  - On any edge where raw = f_x, the counter clears. Glitches shorter than DEB_CYCLES are never seen.
- Temperature:
  - st_q registers ST every edge.
  - heat_req and cool_req are registered flags updated from st_q with the set/clear thresholds above; otherwise each flag holds.
  - The threshold ordering makes heat_req and cool_req mutually exclusive.
- Grant codes:

  | State | display | Output |
  |-------|---------|--------|
  | IDLE  | 000 | none |
  | FD    | 001 | fdoor |
  | RD    | 010 | rdoor |
  | ALARM | 011 | alarmbuzz |
  | WIN   | 100 | winbuzz |
  | HEAT  | 101 | heater |
  | COOL  | 110 | cooler |

  - Code 111 is unreachable. If it is ever reached, the next edge goes to IDLE.
- Request priority: f_SFA > f_SFD > f_SRD > f_SW > heat_req > cool_req. "Best" = the highest asserted request, or IDLE if none.
- Dwell counter:
  - Loaded with HOLD_CYCLES-1 on every edge that enters a non-IDLE state.
  - Decrements toward 0 while the state is unchanged; it reads 0 in IDLE.
- Transitions, evaluated each edge:
  - f_SFA=1 and state ≠ ALARM → ALARM, regardless of dwell (preemption).
  - Dwell counter ≠ 0 → hold.
  - Dwell counter = 0 and best ≠ state → best, in one step, with no pass through IDLE.
  - Dwell counter = 0 and best = state → stay; the counter stays 0, so a higher request is taken on the very next edge.
  - IDLE → best immediately, since its dwell is always 0.
- Outputs are a combinational decode of the state register only. They are glitch-free and never depend on raw inputs.
- Rst=1 on any edge puts the block in this state, overriding everything including mid-dwell and mid-debounce:
  - state = IDLE and dwell = 0;
  - all f_x = 0 and all debounce counters = 0;
  - st_q = 0, heat_req = 0, cool_req = 0.
- Reset value of every output is 0; display = 000.

## Timing
- Sensor latency: raw rises before edge 1 and is held stable.
  - f_x = 1 after edge DEB_CYCLES.
  - State and outputs change after edge DEB_CYCLES+1 (with the dwell permitting).
- Temperature latency: ST changes before edge 1.
  - st_q updates at edge 1.
  - The flag updates at edge 2.
  - State updates at edge 3.
- Minimum grant length is HOLD_CYCLES cycles, except when cut short by fire preemption.
- Simultaneous requests: the highest priority wins, and lower requests wait for dwell expiry.
- A request that drops during dwell is still held until dwell ends, then the block moves to best.
- The first edge after Rst deasserts evaluates normally from the reset state.

## Test plan
Bench parameters: DEB_CYCLES=4, HOLD_CYCLES=8, thresholds at their defaults.

1. **Reset:** hold all sensors at 1, ST=90, Rst=1 for 2 edges → all outputs 0 and display=000 throughout. Rst=0 → alarmbuzz=1 and display=011 five edges later.
2. **Debounce:** pulse SFD for 3 cycles → display stays 000. Hold SFD → fdoor=1 and display=001 after edge 5.
3. **Dwell:** enter FD, then drop SFD 1 cycle later → fdoor stays 1 for exactly 8 cycles, then display=000.
4. **Fire preemption:** in FD with dwell remaining 6, assert SFA → display=011 after 5 edges with no dwell wait. Drop SFA while SFD is held → after the debounce plus ALARM dwell, display returns to 001.
5. **Priority:** assert SRD and SW on the same cycle → rdoor first. Drop SRD → after dwell expiry and debounce, winbuzz=1 and display=100.
6. **Temperature hysteresis:**
   - ST=40 → heater=1 after 3 edges.
   - ST=55 → heater stays 1; ST=60 → display=000 (after dwell).
   - ST=90 → cooler=1; ST=80 → cooler stays 1; ST=75 → display=000.
